// File: rtl/encoder_bank_if.sv
// Bus bundle for encoder_bank: raw quadrature phases in; per-channel value, change strobe,
// error flag and PWM out.
interface encoder_bank_if #(
   parameter int CHANNELS = 3,
   parameter int WIDTH    = 8
);
   logic [CHANNELS-1:0]       a;
   logic [CHANNELS-1:0]       b;
   logic [CHANNELS*WIDTH-1:0] value;
   logic [CHANNELS-1:0]       changed;
   logic [CHANNELS-1:0]       error;
   logic [CHANNELS-1:0]       pwm;

   modport master (output a, b, input value, changed, error, pwm);
   modport slave  (input a, b, output value, changed, error, pwm);
endinterface

// File: rtl/encoder_bank.sv
// Bank of independent quadrature decoders: synchronize, debounce, x4 decode into a
// saturating or wrapping counter, and drive a PWM output from each count.
module encoder_bank #(
   parameter int CHANNELS = 3,
   parameter int WIDTH    = 8,
   parameter int HIST_LEN = 8,
   parameter int STEP     = 1,
   parameter int SATURATE = 1
) (
   input logic          clk,
   input logic          reset,
   encoder_bank_if.slave bus
);

   localparam logic [WIDTH-1:0] MAX_VAL  = '1;
   localparam logic [WIDTH:0]   STEP_EXT = (WIDTH+1)'(STEP);

   logic [CHANNELS-1:0] a_meta, a_sync, b_meta, b_sync;
   logic [WIDTH-1:0]    pwm_cnt;

   function automatic logic [1:0] cw_next(input logic [1:0] s);
      case (s)
         2'b00:   return 2'b01;
         2'b01:   return 2'b11;
         2'b11:   return 2'b10;
         default: return 2'b00;
      endcase
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_meta  <= '0;
         a_sync  <= '0;
         b_meta  <= '0;
         b_sync  <= '0;
         pwm_cnt <= '0;
      end else begin
         a_meta  <= bus.a;
         a_sync  <= a_meta;
         b_meta  <= bus.b;
         b_sync  <= b_meta;
         pwm_cnt <= pwm_cnt + 1'b1;
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic [HIST_LEN-1:0] hist_a, hist_b;
      logic                deb_a, deb_b, prev_a, prev_b;
      logic [WIDTH-1:0]    val, next_val;
      logic                upd, err_hit;
      logic                changed_r, error_r, pwm_r;
      logic [1:0]          cur, prv;
      logic [WIDTH:0]      sum;

      assign cur = {deb_a, deb_b};
      assign prv = {prev_a, prev_b};

      // A step that flips both phases has no direction, so it only raises the error flag.
      always_comb begin
         next_val = val;
         upd      = 1'b0;
         err_hit  = 1'b0;
         sum      = '0;
         if (cur != prv) begin
            if ((cur ^ prv) == 2'b11) begin
               err_hit = 1'b1;
            end else if (cw_next(prv) == cur) begin
               sum = {1'b0, val} + STEP_EXT;
               if (SATURATE != 0 && sum[WIDTH]) next_val = MAX_VAL;
               else                             next_val = sum[WIDTH-1:0];
               upd = (SATURATE == 0) || (next_val != val);
            end else begin
               sum = {1'b0, val} - STEP_EXT;
               if (SATURATE != 0 && sum[WIDTH]) next_val = '0;
               else                             next_val = sum[WIDTH-1:0];
               upd = (SATURATE == 0) || (next_val != val);
            end
         end
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            hist_a    <= '0;
            hist_b    <= '0;
            deb_a     <= 1'b0;
            deb_b     <= 1'b0;
            prev_a    <= 1'b0;
            prev_b    <= 1'b0;
            val       <= '0;
            changed_r <= 1'b0;
            error_r   <= 1'b0;
            pwm_r     <= 1'b0;
         end else begin
            hist_a <= {hist_a[HIST_LEN-2:0], a_sync[g]};
            hist_b <= {hist_b[HIST_LEN-2:0], b_sync[g]};
            if (hist_a == '1)      deb_a <= 1'b1;
            else if (hist_a == '0) deb_a <= 1'b0;
            if (hist_b == '1)      deb_b <= 1'b1;
            else if (hist_b == '0) deb_b <= 1'b0;
            prev_a    <= deb_a;
            prev_b    <= deb_b;
            val       <= next_val;
            changed_r <= upd;
            error_r   <= error_r | err_hit;
            pwm_r     <= (pwm_cnt < val);
         end
      end

      assign bus.value[g*WIDTH +: WIDTH] = val;
      assign bus.changed[g]              = changed_r;
      assign bus.error[g]                = error_r;
      assign bus.pwm[g]                  = pwm_r;
   end

endmodule

// File: doc/encoder_bank.md
ENCODER_BANK -- requirements
Module: encoder_bank

Interface
REQ-001 Parameter CHANNELS, default 3, number of independent encoder channels (1..8).
REQ-002 Parameter WIDTH, default 8, bits per channel value and PWM resolution (4..16).
REQ-003 Parameter HIST_LEN, default 8, debounce history length in clk cycles (2..32).
REQ-004 Parameter STEP, default 1, value change per valid quadrature transition (1..2^(WIDTH-1)).
REQ-005 Parameter SATURATE, default 1, 1 = clamp at 0 / 2^WIDTH-1, 0 = modulo-2^WIDTH wrap.
REQ-006 clk  input  1  sole clock, all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset; all state cleared while low.
REQ-008 a  input  CHANNELS  raw quadrature phase A per channel, asynchronous to clk.
REQ-009 b  input  CHANNELS  raw quadrature phase B per channel, asynchronous to clk.
REQ-010 value  output  CHANNELS*WIDTH  channel i value at bits [i*WIDTH +: WIDTH].
REQ-011 changed  output  CHANNELS  one-cycle pulse when value of channel i updates.
REQ-012 error  output  CHANNELS  sticky flag, set on illegal quadrature transition.
REQ-013 pwm  output  CHANNELS  PWM output per channel, duty = value/2^WIDTH.

Function
REQ-014 Each a/b input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-015 Each synchronized input SHALL shift into a HIST_LEN-bit history register every cycle.
REQ-016 Debounced bit SHALL go 1 the cycle after history is all ones, go 0 the cycle after all zeros, else hold.
REQ-017 Latency: stable raw level sampled at edge k SHALL appear on debounced bit at edge k+HIST_LEN+2.
REQ-018 Decoder SHALL register previous debounced (A,B) per channel and compare with current each cycle.
REQ-019 Gray sequence 00->01->11->10->00 (A is MSB) SHALL be counted as +STEP per transition.
REQ-020 Reverse sequence 00->10->11->01->00 SHALL be counted as -STEP per transition (x4 decoding).
REQ-021 Both bits changing in one cycle SHALL leave value unchanged and set error[i]; error clears only on reset.
REQ-022 value[i] SHALL update on the edge after the debounced transition; changed[i] high that same cycle only.
REQ-023 SATURATE=1: increment beyond 2^WIDTH-1 SHALL yield 2^WIDTH-1, decrement below 0 SHALL yield 0; changed[i] SHALL NOT pulse if value unchanged.
REQ-024 SATURATE=0: arithmetic SHALL wrap modulo 2^WIDTH; changed[i] pulses on every valid transition.
REQ-025 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL all be counted in the same cycle.
REQ-026 A single free-running WIDTH-bit PWM counter SHALL be shared by all channels, wrapping 2^WIDTH-1 -> 0.
REQ-027 pwm[i] SHALL be registered as (counter < value[i]); value 0 -> constant low, value 2^WIDTH-1 -> low exactly 1 cycle per period.
REQ-028 A value change SHALL affect pwm[i] from the next cycle (no period-boundary buffering).

Reset
REQ-029 While reset low: value=0, changed=0, error=0, pwm=0, PWM counter=0, synchronizers, histories, debounced and previous-state registers =0.
REQ-030 Reset asserted mid-rotation SHALL abort immediately; after release, first valid transition counts from value 0 against previous state 00.
REQ-031 Raw inputs held at 11 through reset release SHALL produce 00->11 debounced step, flagged as error, value unchanged.

Verification
REQ-032 Defaults; channel 0 one full CW cycle, each phase held 20 cycles -> value0=4, four changed0 pulses, error0=0.
REQ-033 Channel 1 at 254, two CW transitions, SATURATE=1 -> value1=255, one changed1 pulse; SATURATE=0 -> 255 then 0.
REQ-034 Channel 0 A glitch 5 cycles wide (< HIST_LEN) -> no debounced change, value0 unchanged, no changed0.
REQ-035 Channel 2 at 0, one CCW transition, SATURATE=1 -> value2=0, no pulse; simultaneous CW on channel 0 -> value0=1.
REQ-036 value0=64, WIDTH=8 -> pwm0 high exactly 64 of every 256 cycles; value0=0 -> pwm0 never high.
REQ-037 Force debounced 00->11 on channel 1 -> error1=1 sticky, value1 unchanged; reset pulse -> error1=0, all values 0.
